wb_trace_buffer: RTL

//  Capture FIFO for regfile writeback traffic. Sits downstream of the processor/regfile test top.

---
 rtl/wb_trace_pkg.sv | 22 ++
 rtl/wb_trace_buffer_if.sv | 33 +++
 rtl/wb_trace_fifo.sv | 59 +++++
 rtl/wb_trace_buffer.sv | 85 ++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared widths, payload layout and helpers for the writeback trace buffer.
package wb_trace_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int DROP_W = 16;

   typedef struct packed {
      logic [REG_W-1:0]  wreg;
      logic [DATA_W-1:0] wdata;
   } wb_payload_t;

   localparam int PAYLOAD_W = $bits(wb_payload_t);

   // Stored entry is {stamp, payload}, stamp in the upper bits.
   function automatic int entry_w(input int ts_w);
      return ts_w + PAYLOAD_W;
   endfunction

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/wb_trace_buffer_if.sv
// Writeback capture, drain handshake and status signals of the trace buffer.
interface wb_trace_buffer_if
   import wb_trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TS_W  = 16
) ();
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              capture_en;
   logic              clear;
   logic              wb_we;
   logic [REG_W-1:0]  wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [REG_W-1:0]  out_reg;
   logic [DATA_W-1:0] out_data;
   logic [TS_W-1:0]   out_stamp;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic [DROP_W-1:0] drop_count;

   modport master (
      output capture_en, clear, wb_we, wb_reg, wb_data, out_ready,
      input  out_valid, out_reg, out_data, out_stamp, count, overflow, drop_count
   );

   modport slave (
      input  capture_en, clear, wb_we, wb_reg, wb_data, out_ready,
      output out_valid, out_reg, out_data, out_stamp, count, overflow, drop_count
   );
endinterface

// File: rtl/wb_trace_fifo.sv
// Generic show-ahead synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module wb_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign count_o = wr_q - rd_q;
   assign full_o  = (count_o == FULL_CNT);
   assign empty_o = (wr_q == rd_q);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   // A push into a full FIFO only proceeds when the head leaves on the same edge.
   assign do_pop  = pop_i & ~empty_o & ~clear_i;
   assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (clear_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/wb_trace_buffer.sv
// Time-stamps qualifying regfile writebacks and queues them for a valid/ready consumer.
module wb_trace_buffer
   import wb_trace_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int TS_W       = 16,
   parameter bit CAPTURE_R0 = 1'b0
) (
   input logic               clock,
   input logic               reset,
   wb_trace_buffer_if.slave  bus
);
   localparam int ENTRY_W = entry_w(TS_W);
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic [TS_W-1:0]    ts_q, ts_d;
   logic               overflow_q, overflow_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               push_req, pop, drop;
   logic               full, empty;
   logic [CNT_W-1:0]   fifo_count;
   wb_payload_t        push_pl, head_pl;
   logic [ENTRY_W-1:0] push_entry, head_entry;
   logic [TS_W-1:0]    head_stamp;

   assign push_req = bus.capture_en & bus.wb_we & (CAPTURE_R0 | (bus.wb_reg != '0));
   assign pop      = bus.out_ready & ~empty;
   assign drop     = push_req & full & ~pop & ~bus.clear;

   assign push_pl    = '{wreg: bus.wb_reg, wdata: bus.wb_data};
   assign push_entry = {ts_q, push_pl};

   wb_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock_i (clock),
      .reset_i (reset),
      .push_i  (push_req),
      .pop_i   (pop),
      .clear_i (bus.clear),
      .din_i   (push_entry),
      .dout_o  (head_entry),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

   // The cycle counter keeps running through clear so stamps stay comparable across flushes.
   always_comb begin
      ts_d       = ts_q + 1'b1;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (bus.clear) begin
         overflow_d = 1'b0;
         drop_d     = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         drop_d     = sat_inc(drop_q);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ts_q       <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   assign head_pl    = head_entry[PAYLOAD_W-1:0];
   assign head_stamp = head_entry[ENTRY_W-1 -: TS_W];

   assign bus.out_valid  = ~empty;
   assign bus.out_reg    = empty ? '0 : head_pl.wreg;
   assign bus.out_data   = empty ? '0 : head_pl.wdata;
   assign bus.out_stamp  = empty ? '0 : head_stamp;
   assign bus.count      = fifo_count;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_q;
endmodule
